// File: rtl/ecg_rr_pkg.sv
// Shared types and defaults for the RR-interval tracking slice of the ECG pipeline.
// Holds the beat FSM encoding, timestamp width, averaging depth and rhythm thresholds.
package ecg_rr_pkg;

  localparam int TS_W_DEF    = 16;
  localparam int SPP_DEF     = 8;
  localparam int REFRACT_DEF = 72;
  localparam int BRADY_DEF   = 360;
  localparam int TACHY_DEF   = 216;
  localparam int MAX_RR_DEF  = 1080;

  // Eight-deep averaging window, so the mean is a plain shift by 3.
  localparam int BUF_DEPTH = 8;
  localparam int BUF_AW    = 3;
  localparam logic [BUF_AW:0] BUF_FULL = 4'd8;
  localparam logic [BUF_AW:0] BUF_LAST = 4'd7;

  typedef enum logic [1:0] {
    WAIT_FIRST,
    WAIT_SECOND,
    FILL,
    TRACK
  } rr_state_e;

endpackage

// File: rtl/rr_avg_buffer.sv
// Eight-entry circular RR history with fill count and running sum.
// avg_nxt_o is the mean that will hold once the current write lands.
module rr_avg_buffer
  import ecg_rr_pkg::*;
#(
  parameter int TS_W = TS_W_DEF
) (
  input  logic              clk,
  input  logic              rst_i,
  input  logic              clr_i,
  input  logic              wr_i,
  input  logic [TS_W-1:0]   rr_i,
  output logic [TS_W-1:0]   avg_nxt_o,
  output logic [BUF_AW:0]   fill_o
);

  logic [TS_W-1:0]   mem_q [BUF_DEPTH];
  logic [BUF_AW-1:0] wptr_q;
  logic [BUF_AW:0]   fill_q;
  logic [TS_W+2:0]   sum_q;
  logic [TS_W+2:0]   sum_d;

  // Unwritten slots are zero, so subtracting the overwritten entry is safe while filling.
  always_comb begin
    sum_d = sum_q - {3'b000, mem_q[wptr_q]} + {3'b000, rr_i};
  end

  assign avg_nxt_o = sum_d[TS_W+2:3];
  assign fill_o    = fill_q;

  always_ff @(posedge clk) begin
    if (rst_i || clr_i) begin
      for (int i = 0; i < BUF_DEPTH; i++) mem_q[i] <= '0;
      wptr_q <= '0;
      fill_q <= '0;
      sum_q  <= '0;
    end else if (wr_i) begin
      mem_q[wptr_q] <= rr_i;
      wptr_q        <= wptr_q + 3'd1;
      if (fill_q != BUF_FULL) fill_q <= fill_q + 4'd1;
      sum_q         <= sum_d;
    end
  end

endmodule

// File: rtl/rr_interval_tracker.sv
// Beat-to-beat RR measurement from the QRS detector: refractory gating,
// 8-beat running mean, brady/tachy/irregular flags and asystole timeout.
module rr_interval_tracker
  import ecg_rr_pkg::*;
#(
  parameter int SPP      = SPP_DEF,
  parameter int TS_W     = TS_W_DEF,
  parameter int REFRACT  = REFRACT_DEF,
  parameter int BRADY_RR = BRADY_DEF,
  parameter int TACHY_RR = TACHY_DEF,
  parameter int MAX_RR   = MAX_RR_DEF
) (
  input  logic               clk,
  input  logic               nReset,
  input  logic               push_data,
  input  logic               Rp,
  input  logic signed [16:0] r_peak_ref,
  output logic               rr_valid,
  output logic [TS_W-1:0]    rr_interval,
  output logic [TS_W-1:0]    rr_avg,
  output logic               avg_valid,
  output logic signed [16:0] r_amp,
  output logic [15:0]        beat_count,
  output logic               brady,
  output logic               tachy,
  output logic               irregular,
  output logic               asystole
);

  function automatic logic [15:0] sat_inc16(input logic [15:0] v);
    return (v == 16'hFFFF) ? v : v + 16'd1;
  endfunction

  function automatic logic [TS_W-1:0] abs_diff(input logic [TS_W-1:0] a,
                                               input logic [TS_W-1:0] b);
    return (a >= b) ? a - b : b - a;
  endfunction

  rr_state_e         state_q, state_d;
  logic [TS_W-1:0]   timer_q, last_ts_q, rr_interval_q, rr_avg_q;
  logic              rp_q, armed_q;
  logic              rr_valid_q, avg_valid_q, brady_q, tachy_q, irregular_q, asystole_q;
  logic signed [16:0] r_amp_q;
  logic [15:0]       beat_count_q;

  logic              evt, rr_ok, timeout, buf_wr, buf_clr;
  logic [TS_W-1:0]   rr, avg_nxt;
  logic [BUF_AW:0]   fill;

  // armed_q blocks a level that was already high when reset released from counting as an edge.
  assign evt     = Rp && !rp_q && armed_q;
  assign rr      = timer_q - last_ts_q;
  assign rr_ok   = (rr >= TS_W'(REFRACT));
  assign timeout = (rr > TS_W'(MAX_RR));

  always_comb begin
    state_d = state_q;
    buf_wr  = 1'b0;
    buf_clr = 1'b0;
    case (state_q)
      WAIT_FIRST: if (evt) state_d = WAIT_SECOND;
      WAIT_SECOND, FILL, TRACK: begin
        if (evt) begin
          if (rr_ok) begin
            buf_wr = 1'b1;
            if (state_q == WAIT_SECOND) state_d = FILL;
            else if (state_q == FILL && fill == BUF_LAST) state_d = TRACK;
          end
        end else if (timeout) begin
          buf_clr = 1'b1;
          state_d = WAIT_FIRST;
        end
      end
      default: state_d = WAIT_FIRST;
    endcase
  end

  always_ff @(posedge clk) begin
    if (nReset) begin
      state_q       <= WAIT_FIRST;
      timer_q       <= '0;
      last_ts_q     <= '0;
      rp_q          <= 1'b0;
      armed_q       <= 1'b0;
      rr_valid_q    <= 1'b0;
      rr_interval_q <= '0;
      rr_avg_q      <= '0;
      avg_valid_q   <= 1'b0;
      r_amp_q       <= '0;
      beat_count_q  <= '0;
      brady_q       <= 1'b0;
      tachy_q       <= 1'b0;
      irregular_q   <= 1'b0;
      asystole_q    <= 1'b0;
    end else begin
      state_q     <= state_d;
      timer_q     <= push_data ? timer_q + TS_W'(SPP) : timer_q;
      rp_q        <= Rp;
      armed_q     <= armed_q || !Rp;
      rr_valid_q  <= buf_wr;
      avg_valid_q <= (state_d == TRACK);
      if (evt && state_q == WAIT_FIRST) begin
        last_ts_q    <= timer_q;
        r_amp_q      <= r_peak_ref;
        beat_count_q <= sat_inc16(beat_count_q);
        asystole_q   <= 1'b0;
      end
      if (buf_wr) begin
        last_ts_q     <= timer_q;
        rr_interval_q <= rr;
        rr_avg_q      <= avg_nxt;
        r_amp_q       <= r_peak_ref;
        beat_count_q  <= sat_inc16(beat_count_q);
        brady_q       <= (rr > TS_W'(BRADY_RR));
        tachy_q       <= (rr < TS_W'(TACHY_RR));
        irregular_q   <= avg_valid_q && (abs_diff(rr, rr_avg_q) > (rr_avg_q >> 2));
      end
      if (buf_clr) asystole_q <= 1'b1;
    end
  end

  rr_avg_buffer #(.TS_W(TS_W)) u_buf (
    .clk       (clk),
    .rst_i     (nReset),
    .clr_i     (buf_clr),
    .wr_i      (buf_wr),
    .rr_i      (rr),
    .avg_nxt_o (avg_nxt),
    .fill_o    (fill)
  );

  assign rr_valid    = rr_valid_q;
  assign rr_interval = rr_interval_q;
  assign rr_avg      = rr_avg_q;
  assign avg_valid   = avg_valid_q;
  assign r_amp       = r_amp_q;
  assign beat_count  = beat_count_q;
  assign brady       = brady_q;
  assign tachy       = tachy_q;
  assign irregular   = irregular_q;
  assign asystole    = asystole_q;

endmodule

// File: tb/tb_rr_interval_tracker.sv
// Directed bench for rr_interval_tracker with an RR scoreboard and a queue-based mean model.
module tb_rr_interval_tracker;

  logic               clk = 1'b0;
  logic               nReset, push_data, Rp;
  logic signed [16:0] r_peak_ref;
  logic               rr_valid, avg_valid, brady, tachy, irregular, asystole;
  logic [15:0]        rr_interval, rr_avg, beat_count;
  logic signed [16:0] r_amp;

  always #5 clk = ~clk;

  rr_interval_tracker dut (
    .clk(clk), .nReset(nReset), .push_data(push_data), .Rp(Rp),
    .r_peak_ref(r_peak_ref), .rr_valid(rr_valid), .rr_interval(rr_interval),
    .rr_avg(rr_avg), .avg_valid(avg_valid), .r_amp(r_amp), .beat_count(beat_count),
    .brady(brady), .tachy(tachy), .irregular(irregular), .asystole(asystole)
  );

  typedef struct {
    logic [15:0] rr;
    logic [15:0] avg;
    logic        avgv, brady, tachy, irr;
  } exp_t;

  exp_t               sb[$];
  logic [15:0]        m_rrs[$];
  int                 n_chk = 0;
  int                 n_fail = 0;
  logic [15:0]        tb_timer, m_last, m_cnt, m_avg;
  bit                 m_first, m_avgv;
  logic signed [16:0] m_amp;

  task automatic chk(input string tag, input logic [31:0] obs, input logic [31:0] exp);
    n_chk++;
    assert (obs === exp) else begin
      n_fail++;
      $error("FAIL %s observed=%0d expected=%0d", tag, obs, exp);
    end
  endtask

  task automatic model_reset();
    tb_timer = 16'd0; m_last = 16'd0; m_cnt = 16'd0; m_avg = 16'd0;
    m_first = 1'b0; m_avgv = 1'b0; m_amp = '0;
    m_rrs.delete();
    sb.delete();
  endtask

  task automatic cyc(input logic p, input logic r);
    exp_t e;
    push_data = p;
    Rp = r;
    @(posedge clk);
    #1;
    if (p && !nReset) tb_timer += 16'd8;
    if (rr_valid === 1'b1) begin
      if (sb.size() == 0) chk("spurious_rr_valid", 32'd1, 32'd0);
      else begin
        e = sb.pop_front();
        chk("sb_rr_interval", rr_interval, e.rr);
        chk("sb_rr_avg", rr_avg, e.avg);
        chk("sb_avg_valid", avg_valid, e.avgv);
        chk("sb_brady", brady, e.brady);
        chk("sb_tachy", tachy, e.tachy);
        chk("sb_irregular", irregular, e.irr);
      end
    end
  endtask

  task automatic advance_to(input logic [15:0] t);
    int guard = 0;
    while (tb_timer != t && guard < 2000) begin
      cyc(1'b1, 1'b0);
      guard++;
    end
    if (guard >= 2000) begin
      $display("FAIL advance_to timer=%0d required=%0d", tb_timer, t);
      $fatal(1);
    end
  endtask

  task automatic beat(input logic signed [16:0] amp);
    logic [15:0] rr;
    logic [31:0] sum;
    bit          acc;
    exp_t        e;
    rr  = tb_timer - m_last;
    acc = 1'b0;
    if (!m_first) begin
      m_first = 1'b1; m_last = tb_timer; m_cnt++; m_amp = amp;
    end else if (rr >= 16'd72) begin
      acc   = 1'b1;
      e.irr = m_avgv && (((rr >= m_avg) ? rr - m_avg : m_avg - rr) > (m_avg >> 2));
      if (m_rrs.size() == 8) void'(m_rrs.pop_front());
      m_rrs.push_back(rr);
      sum = 0;
      foreach (m_rrs[i]) sum += 32'(m_rrs[i]);
      m_avg   = sum[18:3];
      m_avgv  = (m_rrs.size() == 8);
      e.rr    = rr;
      e.avg   = m_avg;
      e.avgv  = m_avgv;
      e.brady = (rr > 16'd360);
      e.tachy = (rr < 16'd216);
      sb.push_back(e);
      m_last = tb_timer; m_cnt++; m_amp = amp;
    end
    r_peak_ref = amp;
    cyc(1'b1, 1'b1);
    chk("beat_rr_valid", rr_valid, acc);
    chk("beat_count", beat_count, m_cnt);
    chk("beat_r_amp", r_amp, m_amp);
    chk("beat_avg_valid", avg_valid, m_avgv);
    cyc(1'b1, 1'b0);
  endtask

  task automatic check_all_zero(input string tag);
    chk({tag, "_rr_valid"}, rr_valid, 0);
    chk({tag, "_rr_interval"}, rr_interval, 0);
    chk({tag, "_rr_avg"}, rr_avg, 0);
    chk({tag, "_avg_valid"}, avg_valid, 0);
    chk({tag, "_r_amp"}, r_amp, 0);
    chk({tag, "_beat_count"}, beat_count, 0);
    chk({tag, "_brady"}, brady, 0);
    chk({tag, "_tachy"}, tachy, 0);
    chk({tag, "_irregular"}, irregular, 0);
    chk({tag, "_asystole"}, asystole, 0);
  endtask

  initial begin
    nReset = 1'b1; push_data = 1'b0; Rp = 1'b0; r_peak_ref = '0;
    model_reset();
    cyc(1'b0, 1'b0);
    cyc(1'b0, 1'b0);
    check_all_zero("reset");

    nReset = 1'b0;
    cyc(1'b0, 1'b0);

    // Two beats 288 samples apart.
    beat(17'sd100);
    advance_to(16'd288);
    beat(17'sd120);
    chk("req024_rr", rr_interval, 16'd288);
    chk("req024_brady", brady, 0);
    chk("req024_tachy", tachy, 0);
    chk("req024_count", beat_count, 2);

    // Refractory discard 40 samples later.
    advance_to(16'd328);
    beat(17'sd999);
    chk("req026_count", beat_count, 2);

    for (int k = 2; k <= 8; k++) begin
      advance_to(16'(288 * k));
      beat(17'(100 + k));
    end
    chk("req025_avg_valid", avg_valid, 1);
    chk("req025_avg288", rr_avg, 16'd288);

    advance_to(16'd2704);
    beat(-17'sd500);
    chk("req025_irregular", irregular, 1);
    chk("req025_brady", brady, 1);
    chk("req025_avg302", rr_avg, 16'd302);

    advance_to(16'd2984);
    beat(17'sd200);
    chk("req028_rr280", rr_interval, 16'd280);

    advance_to(16'd3184);
    beat(17'sd210);
    chk("tachy_rr200", tachy, 1);

    // Asystole: diff 1080 is not a timeout, 1088 is.
    advance_to(16'd4272);
    chk("asys_before", asystole, 0);
    cyc(1'b1, 1'b0);
    chk("req027_asystole", asystole, 1);
    chk("req027_avg_valid", avg_valid, 0);
    m_first = 1'b0; m_avgv = 1'b0; m_rrs.delete();
    cyc(1'b1, 1'b0);
    beat(17'sd300);
    chk("req027_asys_clear", asystole, 0);

    for (int k = 1; k <= 8; k++) begin
      advance_to(m_last + 16'd288);
      beat(17'(50 + k));
    end
    chk("track_avg_valid", avg_valid, 1);

    // Reset in TRACK with Rp rising, released with Rp still high.
    nReset = 1'b1;
    cyc(1'b1, 1'b1);
    check_all_zero("midreset");
    model_reset();
    nReset = 1'b0;
    cyc(1'b1, 1'b1);
    cyc(1'b1, 1'b1);
    chk("req029_no_event_count", beat_count, 0);
    chk("req029_no_event_rrv", rr_valid, 0);
    cyc(1'b1, 1'b0);
    beat(17'sd77);

    chk("sb_empty", sb.size(), 0);
    $display("End of test - %0d assertions evaluated, %0d failures", n_chk, n_fail);
    $finish;
  end

endmodule
